// File: rtl/wr_port_arb_pkg.sv
// Shared types and helpers for the wr_port_arb write-port arbiter.
package wr_port_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wr_port_arb_rr_pick.sv
// Combinational cyclic-priority picker: first set request at or after ptr, wrapping.
module rr_pick
    import wr_port_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/wr_port_arb.sv
// Round-robin write-port arbiter with burst locking and a registered output stage.
// Optional: define WR_PORT_ARB_PRIO_EN to give requester 0 priority in IDLE.
module wr_port_arb
    import wr_port_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_vld,
    input  logic [N-1:0]    req_last,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_rdy,
    output logic            wr_vld,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    input  logic            wr_rdy
);

    localparam int PW = ptr_width(N);

    arb_state_e    state, state_nx;
    logic [PW-1:0] owner, owner_nx;
    logic [PW-1:0] ptr, ptr_nx;
    logic [N-1:0]  rr_gnt;
    logic [PW-1:0] rr_idx;
    logic [N-1:0]  win_vec;
    logic [PW-1:0] win;
    logic          out_free;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (req_vld),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    assign out_free = !wr_vld || wr_rdy;

    always_comb begin
        win_vec  = '0;
        win      = '0;
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        sel_addr = '0;
        sel_data = '0;

        if (state == IDLE) begin
            win_vec = rr_gnt;
            win     = rr_idx;
`ifdef WR_PORT_ARB_PRIO_EN
            if (req_vld[0]) begin
                win_vec = N'(1);
                win     = '0;
            end
`endif
        end else begin
            win_vec[owner] = req_vld[owner];
            win            = owner;
        end

        req_rdy = (rst_n && out_free) ? win_vec : '0;
        accept  = |(req_vld & req_rdy);

        if (accept) begin
            if (req_last[win]) begin
                state_nx = IDLE;
                ptr_nx   = (win == PW'(N - 1)) ? '0 : win + 1'b1;
`ifdef WR_PORT_ARB_PRIO_EN
                // Priority requester bursts leave the rotation untouched.
                if (win == '0) ptr_nx = ptr;
`endif
            end else begin
                state_nx = LOCK;
                owner_nx = win;
            end
        end

        for (int unsigned i = 0; i < N; i++) begin
            if (req_rdy[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            wr_vld  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            if (accept) begin
                wr_vld  <= 1'b1;
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end else if (wr_rdy) begin
                wr_vld <= 1'b0;
            end
        end
    end

    // A requester that was valid but not accepted must still be valid next cycle.
    logic [N-1:0] pend;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            assert ((pend & ~req_vld) == '0);
            pend <= req_vld & ~req_rdy;
        end
    end

endmodule

// File: tb/tb_wr_port_arb.sv
// Scoreboard bench for wr_port_arb: per-requester beat queues feed the DUT, a monitor checks the write port.
module tb_wr_port_arb;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef WR_PORT_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_last;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_rdy;
    logic            wr_vld;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_rdy;

    always #5 clk = ~clk;

    wr_port_arb #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_last (req_last),
        .req_addr (req_addr),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .wr_vld   (wr_vld),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_rdy   (wr_rdy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    beat_t bq [N][$];
    exp_t  sb [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int r, input int a, input logic [DW-1:0] d, input bit l);
        beat_t b;
        b.addr = AW'(a);
        b.data = d;
        b.last = l;
        bq[r].push_back(b);
    endtask

    task automatic expect_wr(input int a, input logic [DW-1:0] d);
        exp_t e;
        e.addr = AW'(a);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !wr_vld && (req_vld == '0) &&
                   (bq[0].size() == 0) && (bq[1].size() == 0) &&
                   (bq[2].size() == 0) && (bq[3].size() == 0);
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s drain: %0d beats still expected, wr_vld=%0b", name, sb.size(), wr_vld);
        end
    endtask

    // Requester driver: accept decided at negedge, next head presented just after posedge.
    initial begin
        logic [N-1:0] acc;
        req_vld  = '0;
        req_last = '0;
        req_addr = '0;
        req_data = '0;
        forever begin
            @(negedge clk);
            acc = req_vld & req_rdy & {N{rst_n}};
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && bq[i].size() > 0) void'(bq[i].pop_front());
                if (bq[i].size() > 0) begin
                    req_vld[i]            = 1'b1;
                    req_last[i]           = bq[i][0].last;
                    req_addr[i*AW +: AW]  = bq[i][0].addr;
                    req_data[i*DW +: DW]  = bq[i][0].data;
                end else begin
                    req_vld[i] = 1'b0;
                end
            end
        end
    end

    // Write-port monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wr_vld && wr_rdy) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected beat: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", wr_data, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] t2_rdy [6];
        rst_n  = 1'b0;
        wr_rdy = 1'b1;

        // Round-robin sweep, queued during reset.
        send(0, 1, 32'h0001_0000, 1'b1);
        send(0, 9, 32'h0001_0001, 1'b1);
        send(1, 2, 32'h0001_0100, 1'b1);
        send(2, 3, 32'h0001_0200, 1'b1);
        send(3, 4, 32'h0001_0300, 1'b1);
        if (PRIO) begin
            expect_wr(1, 32'h0001_0000); expect_wr(9, 32'h0001_0001);
            expect_wr(2, 32'h0001_0100); expect_wr(3, 32'h0001_0200);
            expect_wr(4, 32'h0001_0300);
        end else begin
            expect_wr(1, 32'h0001_0000); expect_wr(2, 32'h0001_0100);
            expect_wr(3, 32'h0001_0200); expect_wr(4, 32'h0001_0300);
            expect_wr(9, 32'h0001_0001);
        end
        repeat (2) @(negedge clk);
        chk("reset wr_vld", 32'(wr_vld), 32'(0));
        chk("reset wr_addr", 32'(wr_addr), 32'(0));
        chk("reset wr_data", wr_data, 32'h0);
        chk("reset req_rdy", 32'(req_rdy), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1 first req_rdy", 32'(req_rdy), 32'(4'b0001));
        chk("t1 first wr_vld", 32'(wr_vld), 32'(0));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t1 wr_vld streaming", 32'(wr_vld), 32'(1));
        end
        wait_drain("t1");

        // Single beat from requester 1 leaves ptr at 2.
        send(1, 10, 32'h0002_0100, 1'b1);
        expect_wr(10, 32'h0002_0100);
        wait_drain("t2 prep");

        // Three-beat burst from requester 2 amid competition.
        send(0, 11, 32'h0002_0000, 1'b1);
        send(1, 12, 32'h0002_0101, 1'b1);
        send(2, 5, 32'h0002_0200, 1'b0);
        send(2, 6, 32'h0002_0201, 1'b0);
        send(2, 7, 32'h0002_0202, 1'b1);
        send(3, 13, 32'h0002_0300, 1'b1);
        if (PRIO) begin
            expect_wr(11, 32'h0002_0000);
            expect_wr(5, 32'h0002_0200); expect_wr(6, 32'h0002_0201); expect_wr(7, 32'h0002_0202);
            expect_wr(13, 32'h0002_0300); expect_wr(12, 32'h0002_0101);
            t2_rdy = '{4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0010};
        end else begin
            expect_wr(5, 32'h0002_0200); expect_wr(6, 32'h0002_0201); expect_wr(7, 32'h0002_0202);
            expect_wr(13, 32'h0002_0300); expect_wr(11, 32'h0002_0000); expect_wr(12, 32'h0002_0101);
            t2_rdy = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t2 req_rdy", 32'(req_rdy), 32'(t2_rdy[c]));
        end
        wait_drain("t2");

        // Backpressure: hold wr_rdy low for three cycles with 0xA5 in the output stage.
        @(posedge clk); #1;
        wr_rdy = 1'b0;
        @(negedge clk);
        send(2, 20, 32'h0000_00A5, 1'b1);
        send(3, 21, 32'h0000_00B6, 1'b1);
        expect_wr(20, 32'h0000_00A5);
        expect_wr(21, 32'h0000_00B6);
        @(negedge clk);
        chk("t3 pre-stall req_rdy", 32'(req_rdy), 32'(4'b0100));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3 stall wr_vld", 32'(wr_vld), 32'(1));
            chk("t3 stall wr_data", wr_data, 32'h0000_00A5);
            chk("t3 stall req_rdy", 32'(req_rdy), 32'(0));
        end
        @(posedge clk); #1;
        wr_rdy = 1'b1;
        @(negedge clk);
        chk("t3 resume req_rdy", 32'(req_rdy), 32'(4'b1000));
        wait_drain("t3");

        // Reset after the first beat of a four-beat burst from requester 1.
        send(1, 24, 32'h0004_0100, 1'b0);
        send(1, 25, 32'h0004_0101, 1'b0);
        send(1, 26, 32'h0004_0102, 1'b0);
        send(1, 27, 32'h0004_0103, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4 owner grant", 32'(req_rdy), 32'(4'b0010));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4 req_rdy in reset", 32'(req_rdy), 32'(0));
        send(0, 28, 32'h0004_0000, 1'b1);
        expect_wr(28, 32'h0004_0000);
        expect_wr(25, 32'h0004_0101);
        expect_wr(26, 32'h0004_0102);
        expect_wr(27, 32'h0004_0103);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4 wr_vld after reset", 32'(wr_vld), 32'(0));
        chk("t4 first grant after reset", 32'(req_rdy), 32'(4'b0001));
        wait_drain("t4");

        // ptr = 2 with requesters 0 and 2 valid.
        send(0, 29, 32'h0005_0000, 1'b1);
        send(2, 30, 32'h0005_0200, 1'b1);
        if (PRIO) begin
            expect_wr(29, 32'h0005_0000); expect_wr(30, 32'h0005_0200);
        end else begin
            expect_wr(30, 32'h0005_0200); expect_wr(29, 32'h0005_0000);
        end
        @(negedge clk);
        chk("t5 grant at ptr 2", 32'(req_rdy), PRIO ? 32'(4'b0001) : 32'(4'b0100));
        wait_drain("t5");

        // Locked owner goes idle for five cycles while others wait.
        send(3, 14, 32'h0006_0300, 1'b0);
        expect_wr(14, 32'h0006_0300);
        expect_wr(15, 32'h0006_0301);
        expect_wr(16, 32'h0006_0000);
        expect_wr(17, 32'h0006_0100);
        @(negedge clk);
        chk("t6 lock grant", 32'(req_rdy), 32'(4'b1000));
        @(negedge clk);
        chk("t6 owner idle", 32'(req_rdy), 32'(0));
        send(0, 16, 32'h0006_0000, 1'b1);
        send(1, 17, 32'h0006_0100, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t6 locked no grant", 32'(req_rdy), 32'(0));
        end
        send(3, 15, 32'h0006_0301, 1'b1);
        @(negedge clk);
        chk("t6 burst resumes", 32'(req_rdy), 32'(4'b1000));
        wait_drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
